// File: rtl/ssb_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with byte FIFO on the shared system bus.
// Define UART_TX_IRQ_EN to enable the CTRL register and the registered irq_o output.
module ssb_uart_tx #(
    parameter int unsigned FifoDepth  = 16,
    parameter logic [15:0] DefaultDiv = 16'd867
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int unsigned AW = $clog2(FifoDepth);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem [FifoDepth];
    logic [AW-1:0]   wptr, rptr;
    logic [LW-1:0]   level;
    logic            full, empty, push_req, push_ok, pop;
    logic            sel_data, sel_status, sel_div, sel_ctrl, wr;
    logic [15:0]     div_q, bit_div, baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            tick, ovf_q, ctrl_en;
    logic [31:0]     status_w, rdata_d;
    logic            unused_bits;

    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], be_i[3:2], wdata_i[31:16]};

    assign wr         = req_i & we_i;
    assign sel_data   = addr_i[3:2] == 2'd0;
    assign sel_status = addr_i[3:2] == 2'd1;
    assign sel_div    = addr_i[3:2] == 2'd2;
    assign sel_ctrl   = addr_i[3:2] == 2'd3;

    assign full     = level == LW'(FifoDepth);
    assign empty    = level == '0;
    assign push_req = wr & sel_data & be_i[0];
    assign pop      = (state_q == IDLE) & ~empty;
    // A full FIFO still accepts a push when the transmitter pops in the same cycle.
    assign push_ok  = push_req & (~full | pop);

    always_ff @(posedge clk_sys) begin
        if (push_ok) mem[wptr] <= wdata_i[7:0];
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop)     rptr <= rptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            div_q <= DefaultDiv;
            ovf_q <= 1'b0;
        end else begin
            if (wr && sel_div) begin
                if (be_i[0]) div_q[7:0]  <= wdata_i[7:0];
                if (be_i[1]) div_q[15:8] <= wdata_i[15:8];
            end
            if (push_req && full && !pop)
                ovf_q <= 1'b1;
            else if (wr && sel_status && be_i[0] && wdata_i[3])
                ovf_q <= 1'b0;
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            ctrl_en <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (wr && sel_ctrl && be_i[0]) ctrl_en <= wdata_i[0];
            irq_q <= ctrl_en & ((empty & (state_q == IDLE)) | ovf_q);
        end
    end

    assign irq_o = irq_q;
`else
    assign ctrl_en = 1'b0;
    assign irq_o   = 1'b0;
`endif

    assign tick = baud_cnt == bit_div;

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = START;
            START:   if (tick) state_d = DATA;
            DATA:    if (tick && bit_cnt == 3'd7) state_d = STOP;
            STOP:    if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            START:   tx_o = 1'b0;
            DATA:    tx_o = shreg[0];
            default: tx_o = 1'b1;
        endcase
    end

    // Divisor is captured at pop so DIV writes only affect the next frame.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            shreg    <= '0;
            bit_div  <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state_q == IDLE) begin
            if (!empty) begin
                shreg    <= mem[rptr];
                bit_div  <= div_q;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end
        end else if (tick) begin
            baud_cnt <= '0;
            if (state_q == DATA) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end else begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

    always_comb begin
        status_w           = '0;
        status_w[0]        = full;
        status_w[1]        = empty;
        status_w[2]        = (state_q != IDLE) | ~empty;
        status_w[3]        = ovf_q;
        status_w[8 +: LW]  = level;
    end

    always_comb begin
        rdata_d = '0;
        if (req_i && !we_i) begin
            if (sel_status)    rdata_d = status_w;
            else if (sel_div)  rdata_d = {16'h0, div_q};
            else if (sel_ctrl) rdata_d = {31'h0, ctrl_en};
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) rdata_o <= '0;
        else            rdata_o <= rdata_d;
    end

endmodule
